blake2s_block_feeder: RTL

- Upstream of the BLAKE2s core. Converts a byte stream into the core's block interface.
- Input stream carries optional key bytes first, then message bytes, with valid/ready flow control.
- Emits 64-byte blocks with data_idx, block_first and block_last. The key block and the final block are zero-padded.
- Keeps the message byte count ll and waits for core ready before starting each block.

---
 rtl/blake2s_block_feeder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/blake2s_block_feeder.sv
// Byte-stream to BLAKE2s block adapter: key block first (zero-padded), then
// 64-byte message blocks with the final one zero-padded, framed by index/first/last.
module blake2s_block_feeder #(
    parameter int LL_W = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [5:0]      kk_i,
    input  logic            msg_empty_i,
    input  logic            in_v_i,
    input  logic [7:0]      in_data_i,
    input  logic            in_last_i,
    output logic            in_ready_o,
    input  logic            ready_v_i,
    output logic            data_v_o,
    output logic [7:0]      data_o,
    output logic [5:0]      data_idx_o,
    output logic            block_first_o,
    output logic            block_last_o,
    output logic [LL_W-1:0] ll_o,
    output logic            busy_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_RDY = 3'd1;
    localparam logic [2:0] S_KEY      = 3'd2;
    localparam logic [2:0] S_MSG      = 3'd3;
    localparam logic [2:0] S_PAD      = 3'd4;
    localparam logic [2:0] S_GAP      = 3'd5;

    localparam logic [LL_W-1:0] LL_ONE = 1;

    logic [2:0] state;
    logic [5:0] kk;
    logic [5:0] idx;
    logic       empty;
    logic       first;
    logic       final_blk;

    assign in_ready_o = (state == S_KEY) || (state == S_MSG);

    // Every emitted beat is registered here; kk is cleared once the key block
    // is consumed so the next WAIT_RDY heads straight into message blocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            kk            <= '0;
            idx           <= '0;
            empty         <= 1'b0;
            first         <= 1'b0;
            final_blk     <= 1'b0;
            data_v_o      <= 1'b0;
            data_o        <= '0;
            data_idx_o    <= '0;
            block_first_o <= 1'b0;
            block_last_o  <= 1'b0;
            ll_o          <= '0;
            busy_o        <= 1'b0;
        end else begin
            data_v_o      <= 1'b0;
            block_first_o <= 1'b0;
            block_last_o  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        kk        <= (kk_i > 6'd32) ? 6'd32 : kk_i;
                        empty     <= msg_empty_i;
                        ll_o      <= '0;
                        idx       <= '0;
                        first     <= 1'b1;
                        final_blk <= 1'b0;
                        busy_o    <= 1'b1;
                        state     <= S_WAIT_RDY;
                    end
                end
                S_WAIT_RDY: begin
                    if (ready_v_i) begin
                        if (kk != 6'd0) begin
                            state <= S_KEY;
                        end else if (!empty) begin
                            state <= S_MSG;
                        end else begin
                            state     <= S_PAD;
                            final_blk <= 1'b1;
                        end
                    end
                end
                S_KEY: begin
                    if (in_v_i) begin
                        data_v_o      <= 1'b1;
                        data_o        <= in_data_i;
                        data_idx_o    <= idx;
                        block_first_o <= first;
                        idx           <= idx + 6'd1;
                        if (idx == kk - 6'd1) begin
                            state     <= S_PAD;
                            final_blk <= empty;
                            kk        <= '0;
                        end
                    end
                end
                S_MSG: begin
                    if (in_v_i) begin
                        data_v_o      <= 1'b1;
                        data_o        <= in_data_i;
                        data_idx_o    <= idx;
                        block_first_o <= first;
                        idx           <= idx + 6'd1;
                        ll_o          <= ll_o + LL_ONE;
                        if (idx == 6'd63) begin
                            block_last_o <= in_last_i;
                            first        <= 1'b0;
                            busy_o       <= !in_last_i;
                            state        <= in_last_i ? S_IDLE : S_GAP;
                        end else if (in_last_i) begin
                            state     <= S_PAD;
                            final_blk <= 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    data_v_o      <= 1'b1;
                    data_o        <= 8'h00;
                    data_idx_o    <= idx;
                    block_first_o <= first;
                    idx           <= idx + 6'd1;
                    if (idx == 6'd63) begin
                        block_last_o <= final_blk;
                        first        <= 1'b0;
                        busy_o       <= !final_blk;
                        state        <= final_blk ? S_IDLE : S_GAP;
                    end
                end
                S_GAP: begin
                    state <= S_WAIT_RDY;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
